// File: rtl/uart_tx_fifo_if.sv
// Byte-write handshake into the buffered UART transmitter.
// master drives data/valid, slave (the transmitter) returns ready.
interface uart_tx_fifo_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] in_data;
  logic                 in_valid;
  logic                 in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO-fed, back-to-back 8N1 frames on tx, LSB first.
// Optional even parity bit when UART_TX_PARITY_EN is defined (8E1 frames).
//
// state  | meaning
// IDLE   | line high, waiting for a queued byte
// START  | start bit (low)
// DATA   | payload bits, LSB first
// PARITY | even parity bit (UART_TX_PARITY_EN only)
// STOP   | stop bit (high); chains into START when more data is queued
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  uart_tx_fifo_if.slave                 intf,
  output logic                          tx,
  output logic                          busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CW    = PTR_W + 1;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t               state;
  logic [BAUD_W-1:0]    baud_cnt;
  logic [BIT_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
`ifdef UART_TX_PARITY_EN
  logic                 parity_bit;
`endif

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic bit_end;

  assign full    = (fifo_count == CW'(FIFO_DEPTH));
  assign empty   = (fifo_count == '0);
  assign bit_end = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
  assign push    = intf.in_valid && !full;
  // Pops only from IDLE or on the final STOP cycle so the next frame starts with no gap.
  assign pop     = !empty && ((state == IDLE) || ((state == STOP) && bit_end));

  assign intf.in_ready = !full;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= intf.in_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Line outputs are registered from the current state, so tx trails the state by one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      tx_done  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      busy    <= (state != IDLE);
      tx_done <= (state == STOP) && bit_end;
      case (state)
        IDLE: begin
          tx       <= 1'b1;
          baud_cnt <= '0;
          if (pop) begin
            shift <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
            parity_bit <= ^mem[rd_ptr];
`endif
            state <= START;
          end
        end
        START: begin
          tx <= 1'b0;
          if (bit_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        DATA: begin
          tx <= shift[0];
          if (bit_end) begin
            baud_cnt <= '0;
            shift    <= shift >> 1;
            if (bit_idx == BIT_W'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + BIT_W'(1);
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          tx <= parity_bit;
          if (bit_end) begin
            baud_cnt <= '0;
            state    <= STOP;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
`endif
        STOP: begin
          tx <= 1'b1;
          if (bit_end) begin
            baud_cnt <= '0;
            if (pop) begin
              shift <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
              parity_bit <= ^mem[rd_ptr];
`endif
              state <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        default: begin
          tx       <= 1'b1;
          baud_cnt <= '0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: per-cycle compare against a line-waveform reference model.
// Build with UART_TX_PARITY_EN defined to exercise 8E1 frames.
module tb_uart_tx_fifo;
  localparam int CPB   = 4;
  localparam int DB    = 8;
  localparam int DEPTH = 8;

  typedef struct {
    logic tx;
    logic busy;
    logic done;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tx;
  logic busy;
  logic tx_done;
  logic [$clog2(DEPTH):0] fifo_count;

  uart_tx_fifo_if #(.DATA_BITS(DB)) intf ();

  uart_tx_fifo #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS(DB),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .intf(intf),
    .tx(tx),
    .busy(busy),
    .tx_done(tx_done),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int n_acc;
  logic last_accept;
  logic [DB-1:0] fifo_q[$];
  ent_t wave[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One frame on the line: start, LSB-first data, optional even parity, stop; each bit CPB cycles.
  task automatic add_frame(input logic [DB-1:0] b);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < DB; i++) bits.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
    bits.push_back(^b);
`endif
    bits.push_back(1'b1);
    for (int i = 0; i < bits.size(); i++) begin
      for (int c = 0; c < CPB; c++) begin
        wave.push_back('{bits[i], 1'b1, (i == bits.size() - 1) && (c == CPB - 1)});
      end
    end
  endtask

  task automatic step();
    ent_t cur;
    logic ready_pre;
    @(posedge clk);
    ready_pre   = (fifo_q.size() < DEPTH);
    last_accept = intf.in_valid && ready_pre;
    if (wave.size() > 0) cur = wave.pop_front();
    else cur = '{1'b1, 1'b0, 1'b0};
    // Line free (idle or final stop cycle) and data waiting: next frame starts right behind.
    if ((!cur.busy || cur.done) && fifo_q.size() > 0) add_frame(fifo_q.pop_front());
    if (last_accept) fifo_q.push_back(intf.in_data);
    #1;
    chk("tx", 32'(tx), 32'(cur.tx));
    chk("busy", 32'(busy), 32'(cur.busy));
    chk("tx_done", 32'(tx_done), 32'(cur.done));
    chk("fifo_count", 32'(fifo_count), 32'(fifo_q.size()));
    chk("in_ready", 32'(intf.in_ready), 32'(fifo_q.size() < DEPTH));
  endtask

  task automatic push_byte(input logic [DB-1:0] b);
    intf.in_valid = 1'b1;
    intf.in_data  = b;
    step();
    intf.in_valid = 1'b0;
    intf.in_data  = $urandom;
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    intf.in_valid = 1'b0;
    intf.in_data  = '0;
    #12;
    chk("reset_tx", 32'(tx), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(tx_done), 32'd0);
    chk("reset_ready", 32'(intf.in_ready), 32'd1);
    chk("reset_count", 32'(fifo_count), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    idle_steps(3);

    // single byte
    push_byte(8'hA5);
    idle_steps(50);

    // two bytes back to back
    push_byte(8'h55);
    push_byte(8'hAA);
    idle_steps(90);
    chk("b2b_empty", 32'(fifo_count), 32'd0);

    // fill until full with incrementing data
    n_acc = 0;
    intf.in_valid = 1'b1;
    intf.in_data  = 8'h00;
    for (int i = 0; i < 40; i++) begin
      step();
      if (last_accept) begin
        n_acc++;
        intf.in_data = intf.in_data + 8'd1;
      end
      if (!intf.in_ready) break;
    end
    chk("full_accepted", 32'(n_acc), 32'd9);
    for (int i = 0; i < 60; i++) begin
      step();
      if (last_accept) intf.in_data = intf.in_data + 8'd1;
    end
    intf.in_valid = 1'b0;
    idle_steps(600);
    chk("full_drained", 32'(fifo_count), 32'd0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      intf.in_valid = ($urandom_range(0, 3) == 0);
      intf.in_data  = DB'($urandom);
      step();
    end
    intf.in_valid = 1'b0;
    idle_steps(500);

`ifdef UART_TX_PARITY_EN
    push_byte(8'h07);
    idle_steps(50);
    push_byte(8'h03);
    idle_steps(50);
`endif

    // reset during data bit 3 with two bytes queued
    push_byte(8'h3C);
    push_byte(8'h11);
    push_byte(8'h22);
    idle_steps(17);
    chk("pre_reset_busy", 32'(busy), 32'd1);
    chk("pre_reset_count", 32'(fifo_count), 32'd2);
    #2;
    rst = 1'b0;
    #1;
    chk("async_tx", 32'(tx), 32'd1);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_count", 32'(fifo_count), 32'd0);
    chk("async_ready", 32'(intf.in_ready), 32'd1);
    fifo_q.delete();
    wave.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    idle_steps(60);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
